// File: rtl/custom_leds_pwm.sv
// Avalon-MM LED peripheral: per-channel off/on/PWM/blink with period-shadowed duty,
// a shared blink prescaler and global enable / output polarity.
module custom_leds_pwm #(
   parameter int NUM_LEDS      = 8,
   parameter int PWM_BITS      = 8,
   parameter int ADDR_W        = 6,
   parameter int BLINK_DIV_RST = 25000000
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   avs_address,
   input  logic                avs_read,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   output logic [31:0]         avs_readdata,
   output logic [NUM_LEDS-1:0] leds
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_PWM   = 2'd2,
      MODE_BLINK = 2'd3
   } mode_e;

   localparam logic [ADDR_W-1:0]   ADDR_CTRL  = '0;
   localparam logic [ADDR_W-1:0]   ADDR_BLINK = ADDR_W'(1);
   localparam logic [PWM_BITS-1:0] PWM_LAST   = '1;

   logic                               r_en;
   logic                               r_inv;
   logic [31:0]                        r_blinkDiv;
   logic [NUM_LEDS-1:0][PWM_BITS-1:0]  r_duty;
   logic [NUM_LEDS-1:0][1:0]           r_mode;
   logic [NUM_LEDS-1:0][PWM_BITS-1:0]  r_shadow;
   logic [PWM_BITS-1:0]                r_pwmCnt;
   logic [31:0]                        r_blinkCnt;
   logic                               r_blinkPhase;

   logic                w_wrCtrl;
   logic                w_wrBlink;
   logic [NUM_LEDS-1:0] w_wrChan;
   logic                w_pwmLast;
   logic                w_blinkWrap;
   logic [NUM_LEDS-1:0] w_pwmOn;
   logic [NUM_LEDS-1:0] w_raw;
   logic [31:0]         w_rdData;
   logic                w_unusedWr;

   assign w_unusedWr = ^avs_writedata;

   always_comb begin
      w_wrCtrl  = avs_write && (avs_address == ADDR_CTRL);
      w_wrBlink = avs_write && (avs_address == ADDR_BLINK);
      w_wrChan  = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         w_wrChan[i] = avs_write && (avs_address == ADDR_W'(i + 2));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en       <= 1'b0;
         r_inv      <= 1'b0;
         r_blinkDiv <= 32'(BLINK_DIV_RST);
         r_duty     <= '0;
         r_mode     <= '0;
      end else begin
         if (w_wrCtrl) begin
            r_en  <= avs_writedata[0];
            r_inv <= avs_writedata[1];
         end
         if (w_wrBlink) begin
            r_blinkDiv <= avs_writedata;
         end
         for (int i = 0; i < NUM_LEDS; i++) begin
            if (w_wrChan[i]) begin
               r_duty[i] <= avs_writedata[PWM_BITS-1:0];
               r_mode[i] <= avs_writedata[17:16];
            end
         end
      end
   end

   // Shadow duties load from the pre-write register value on the last count,
   // so a duty write landing on that same cycle waits one more period.
   assign w_pwmLast = (r_pwmCnt == PWM_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pwmCnt <= '0;
         r_shadow <= '0;
      end else begin
         r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
         if (w_pwmLast) begin
            r_shadow <= r_duty;
         end
      end
   end

   assign w_blinkWrap = (r_blinkCnt == (r_blinkDiv - 32'd1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blinkCnt   <= '0;
         r_blinkPhase <= 1'b0;
      end else if (w_wrBlink || (r_blinkDiv == 32'd0)) begin
         r_blinkCnt   <= '0;
         r_blinkPhase <= 1'b0;
      end else if (w_blinkWrap) begin
         r_blinkCnt   <= '0;
         r_blinkPhase <= ~r_blinkPhase;
      end else begin
         r_blinkCnt   <= r_blinkCnt + 32'd1;
      end
   end

   always_comb begin
      w_pwmOn = '0;
      w_raw   = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         w_pwmOn[i] = (r_pwmCnt < r_shadow[i]);
         case (mode_e'(r_mode[i]))
            MODE_OFF:   w_raw[i] = 1'b0;
            MODE_ON:    w_raw[i] = 1'b1;
            MODE_PWM:   w_raw[i] = w_pwmOn[i];
            MODE_BLINK: w_raw[i] = r_blinkPhase & w_pwmOn[i];
            default:    w_raw[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         leds <= '0;
      end else if (r_en) begin
         leds <= w_raw ^ {NUM_LEDS{r_inv}};
      end else begin
         leds <= {NUM_LEDS{r_inv}};
      end
   end

   always_comb begin
      w_rdData = '0;
      if (avs_address == ADDR_CTRL) begin
         w_rdData = {30'd0, r_inv, r_en};
      end else if (avs_address == ADDR_BLINK) begin
         w_rdData = r_blinkDiv;
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
         if (avs_address == ADDR_W'(i + 2)) begin
            w_rdData = {14'd0, r_mode[i], 16'(r_duty[i])};
         end
      end
   end

   // Read data is captured from current register state, so a same-cycle
   // write to the same address returns the old value.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         avs_readdata <= w_rdData;
      end
   end

endmodule
